scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_pkg.sv | 18 +
 rtl/scan_misr.sv | 33 +++
 rtl/scan_test_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_test_pkg.sv
// Shared types and constants for the scan test controller and its MISR.
package scan_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    localparam int PAT_CNT_W = 8;
    localparam int MISR_W    = 16;
    // x^16 + x^12 + x^3 + x + 1, x^16 term implicit
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h100B;

endpackage

// File: rtl/scan_misr.sv
// Serial-input 16-bit MISR folding compared scan_out bits into a signature, seed 0.
module scan_misr
    import scan_test_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q, sig_d;
    logic              fb;

    always_comb begin
        fb    = sig_q[MISR_W-1] ^ din;
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: loads patterns into an external chain, captures, unloads and compares.
// Define SCAN_TEST_CTRL_MISR_EN to fold compared bits into a 16-bit MISR signature.
//
// state   | meaning
// IDLE    | waiting for start, chain frozen
// LOAD    | pat_ready high, waiting for next pattern
// SHIFT   | CHAIN_LEN cycles shifting stimulus in / previous response out
// CAPTURE | one functional capture clock
// UNLOAD  | CHAIN_LEN cycles shifting out the last response
// DONE    | one-cycle done pulse
module scan_test_ctrl
    import scan_test_pkg::*;
#(
    parameter int CHAIN_LEN = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAT_CNT_W-1:0] num_patterns,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 chain_hold,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [MISR_W-1:0]    signature
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [PAT_CNT_W-1:0] pat_left_q, pat_left_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] cmp_q, cmp_d;
    logic                 have_prev_q, have_prev_d;
    logic [CNT_W-1:0]     mism_q, mism_d;
    logic                 fail_q, fail_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;
    logic                 hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sin_nxt;
    logic                 cmp_en;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        pat_left_d  = pat_left_q;
        sh_d        = sh_q;
        exp_d       = exp_q;
        cmp_d       = cmp_q;
        have_prev_d = have_prev_q;
        mism_d      = mism_q;
        fail_d      = fail_q;
        sin_nxt     = sh_q[CHAIN_LEN-1];
        cmp_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mism_d      = '0;
                    fail_d      = 1'b0;
                    have_prev_d = 1'b0;
                    pat_left_d  = num_patterns;
                    state_d     = (num_patterns != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (pat_valid && pat_ready_q) begin
                    state_d    = ST_SHIFT;
                    bit_d      = BIT_LAST;
                    pat_left_d = pat_left_q - PAT_CNT_W'(1);
                    sh_d       = pat_data << 1;
                    sin_nxt    = pat_data[CHAIN_LEN-1];
                    // previous pattern's expectation is compared while this one shifts in
                    cmp_d      = exp_q;
                    exp_d      = pat_expect;
                end
            end
            ST_SHIFT: begin
                cmp_en = have_prev_q;
                cmp_d  = cmp_q << 1;
                sh_d   = sh_q << 1;
                if (bit_q == '0) state_d = ST_CAPTURE;
                else             bit_d   = bit_q - BW'(1);
            end
            ST_CAPTURE: begin
                have_prev_d = 1'b1;
                if (pat_left_q != '0) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_UNLOAD;
                    bit_d   = BIT_LAST;
                    cmp_d   = exp_q;
                end
            end
            ST_UNLOAD: begin
                cmp_en = 1'b1;
                cmp_d  = cmp_q << 1;
                if (bit_q == '0) state_d = ST_DONE;
                else             bit_d   = bit_q - BW'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (cmp_en && (scan_out != cmp_q[CHAIN_LEN-1])) begin
            fail_d = 1'b1;
            if (mism_q != '1) mism_d = mism_q + CNT_W'(1);
        end

        busy_d      = state_d inside {ST_LOAD, ST_SHIFT, ST_CAPTURE, ST_UNLOAD};
        hold_d      = state_d inside {ST_IDLE, ST_LOAD, ST_DONE};
        scan_en_d   = state_d inside {ST_SHIFT, ST_UNLOAD};
        pat_ready_d = (state_d == ST_LOAD);
        done_d      = (state_d == ST_DONE);
        scan_in_d   = (state_d == ST_SHIFT) ? sin_nxt : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            pat_left_q  <= '0;
            sh_q        <= '0;
            exp_q       <= '0;
            cmp_q       <= '0;
            have_prev_q <= 1'b0;
            mism_q      <= '0;
            fail_q      <= 1'b0;
            pat_ready_q <= 1'b0;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            hold_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            pat_left_q  <= pat_left_d;
            sh_q        <= sh_d;
            exp_q       <= exp_d;
            cmp_q       <= cmp_d;
            have_prev_q <= have_prev_d;
            mism_q      <= mism_d;
            fail_q      <= fail_d;
            pat_ready_q <= pat_ready_d;
            scan_en_q   <= scan_en_d;
            scan_in_q   <= scan_in_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pat_ready      = pat_ready_q;
    assign scan_en        = scan_en_q;
    assign scan_in        = scan_in_q;
    assign chain_hold     = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = fail_q;
    assign mismatch_count = mism_q;

`ifdef SCAN_TEST_CTRL_MISR_EN
    logic misr_clr;
    assign misr_clr = (state_q == ST_IDLE) && start;

    scan_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (misr_clr),
        .en    (cmp_en),
        .din   (scan_out),
        .sig   (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: behavioural scan chain plus a per-pattern response model.
module tb_scan_test_ctrl;

    localparam int L  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_patterns = '0;
    logic          pat_valid = 1'b0;
    logic [L-1:0]  pat_data = '0;
    logic [L-1:0]  pat_expect = '0;
    logic          pat_ready, scan_en, scan_in, chain_hold, scan_out;
    logic          busy, done, fail;
    logic [CW-1:0] mismatch_count;
    logic [15:0]   signature;

    always #5 clk = ~clk;

    scan_test_ctrl #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_patterns   (num_patterns),
        .pat_valid      (pat_valid),
        .pat_ready      (pat_ready),
        .pat_data       (pat_data),
        .pat_expect     (pat_expect),
        .scan_en        (scan_en),
        .scan_in        (scan_in),
        .chain_hold     (chain_hold),
        .scan_out       (scan_out),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .mismatch_count (mismatch_count),
        .signature      (signature)
    );

    // functional response of the circuit under test, applied on capture
    function automatic logic [L-1:0] resp(input logic [L-1:0] x, input int mode, input logic [L-1:0] mask);
        logic [L-1:0] r;
        r = x;
        if (mode == 1) begin
            for (int i = 0; i < L; i++) r[i] = x[L-1-i];
        end else if (mode == 2) begin
            r = x ^ mask;
        end
        return r;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        logic fb;
        fb = s[15] ^ d;
        return {s[14:0], 1'b0} ^ ({16{fb}} & 16'h100B);
    endfunction

    logic [L-1:0] chain = '0;
    int           cur_mode = 0;
    logic [L-1:0] cur_mask = '0;
    assign scan_out = chain[L-1];

    always @(posedge clk) begin
        if (!chain_hold) chain <= scan_en ? {chain[L-2:0], scan_in} : resp(chain, cur_mode, cur_mask);
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_patterns = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic give_pat(input logic [L-1:0] p, input logic [L-1:0] e, input int stall);
        int i;
        logic [L-1:0] snap;
        i = 0;
        while (!pat_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("pat_ready", {31'b0, pat_ready}, 1);
        snap = chain;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_hold", {31'b0, chain_hold}, 1);
            chk("stall_chain", {30'b0, chain}, {30'b0, snap});
        end
        pat_valid = 1'b1;
        pat_data = p;
        pat_expect = e;
        @(posedge clk);
        @(negedge clk);
        pat_valid = 1'b0;
        pat_data = L'($urandom);
        pat_expect = L'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!done && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done"}, {31'b0, done}, 1);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
    endtask

    task automatic run(input string tag, input int n, input int stall_at, input bit poke, input int mode);
        logic [L-1:0] p[$];
        logic [L-1:0] e[$];
        logic [L-1:0] r;
        int           mm;
        logic [15:0]  sig;
        cur_mode = mode;
        cur_mask = L'($urandom);
        mm = 0;
        sig = '0;
        for (int j = 0; j < n; j++) begin
            p.push_back(L'($urandom));
            e.push_back(L'($urandom));
            r = resp(p[j], mode, cur_mask);
            mm += $countones(r ^ e[j]);
            for (int b = L - 1; b >= 0; b--) sig = misr_step(sig, r[b]);
        end
        do_start(n);
        if (poke) begin
            start = 1'b1;
            num_patterns = 8'd0;
            @(negedge clk);
            start = 1'b0;
        end
        for (int j = 0; j < n; j++) give_pat(p[j], e[j], (j == stall_at) ? 5 : 0);
        wait_done(tag);
        chk({tag, "_mismatch"}, {16'b0, mismatch_count}, 32'(mm));
        chk({tag, "_fail"}, {31'b0, fail}, {31'b0, mm != 0});
`ifdef SCAN_TEST_CTRL_MISR_EN
        chk({tag, "_sig"}, {16'b0, signature}, {16'b0, sig});
`else
        chk({tag, "_sig"}, {16'b0, signature}, 0);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pat_ready"}, {31'b0, pat_ready}, 0);
        chk({tag, "_scan_en"}, {31'b0, scan_en}, 0);
        chk({tag, "_scan_in"}, {31'b0, scan_in}, 0);
        chk({tag, "_chain_hold"}, {31'b0, chain_hold}, 1);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_fail"}, {31'b0, fail}, 0);
        chk({tag, "_mismatch"}, {16'b0, mismatch_count}, 0);
        chk({tag, "_sig"}, {16'b0, signature}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        reset = 1'b1;
        @(negedge clk);

        // zero patterns: done on the next cycle, never busy
        do_start(0);
        chk("zero_done", {31'b0, done}, 1);
        chk("zero_busy", {31'b0, busy}, 0);
        @(negedge clk);
        chk("zero_done_clr", {31'b0, done}, 0);
        chk("zero_busy2", {31'b0, busy}, 0);

        // single pattern, matching response: cycle-by-cycle trace
        cur_mode = 0;
        do_start(1);
        give_pat(2'b10, 2'b10, 0);
        chk("d1_shift0_en", {31'b0, scan_en}, 1);
        chk("d1_shift0_in", {31'b0, scan_in}, 1);
        chk("d1_shift0_hold", {31'b0, chain_hold}, 0);
        chk("d1_shift0_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("d1_shift1_in", {31'b0, scan_in}, 0);
        chk("d1_shift1_en", {31'b0, scan_en}, 1);
        @(negedge clk);
        chk("d1_capt_en", {31'b0, scan_en}, 0);
        chk("d1_capt_hold", {31'b0, chain_hold}, 0);
        @(negedge clk);
        chk("d1_unl0_en", {31'b0, scan_en}, 1);
        chk("d1_unl0_in", {31'b0, scan_in}, 0);
        chk("d1_unl0_done", {31'b0, done}, 0);
        @(negedge clk);
        chk("d1_unl1_en", {31'b0, scan_en}, 1);
        @(negedge clk);
        chk("d1_done", {31'b0, done}, 1);
        chk("d1_busy", {31'b0, busy}, 0);
        chk("d1_mismatch", {16'b0, mismatch_count}, 0);
        chk("d1_fail", {31'b0, fail}, 0);
`ifdef SCAN_TEST_CTRL_MISR_EN
        chk("d1_sig_nonzero", {31'b0, signature != 16'h0}, 1);
`else
        chk("d1_sig_zero", {16'b0, signature}, 0);
`endif
        @(negedge clk);
        chk("d1_done_pulse", {31'b0, done}, 0);

        // response 01 against expect 10: two mismatching bits
        cur_mode = 1;
        do_start(1);
        give_pat(2'b10, 2'b10, 0);
        wait_done("d2");
        chk("d2_mismatch", {16'b0, mismatch_count}, 2);
        chk("d2_fail", {31'b0, fail}, 1);
        @(negedge clk);
        chk("d2_hold_mismatch", {16'b0, mismatch_count}, 2);

        for (int k = 0; k < 6; k++) begin
            run("rnd", $urandom_range(1, 6), -1, k == 2, $urandom_range(0, 2));
        end
        run("stall", 3, 1, 1'b0, 2);

        // reset in the middle of a shift
        do_start(2);
        give_pat(2'b11, 2'b00, 0);
        reset = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run("post_rst", 3, -1, 1'b0, 2);

        run("p255", 255, -1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
